// File: rtl/regfile_pkg.sv
// Shared constants and types for the multiport register file and its busy scoreboard.
package regfile_pkg;

    localparam int DEFAULT_DATA_W   = 16;
    localparam int DEFAULT_NUM_REGS = 8;

    // Address width for a bank of numRegs registers; never narrower than one bit.
    function automatic int addrWidth(input int numRegs);
        return (numRegs <= 2) ? 1 : $clog2(numRegs);
    endfunction

    localparam int DEFAULT_ADDR_W = addrWidth(DEFAULT_NUM_REGS);

    typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: a write retires a pending producer, an issue claims a register.
// When both target the same register on one edge the issue wins, so the bit stays set.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = addrWidth(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                regWrite,
    input  logic [ADDR_W-1:0]   wrAddr,
    input  logic                issueValid,
    input  logic [ADDR_W-1:0]   issueAddr,
    output logic [NUM_REGS-1:0] busyVec
);

    logic [NUM_REGS-1:0] busyNext;

    always_comb begin
        busyNext = busyVec;
        if (regWrite) begin
            busyNext[wrAddr] = 1'b0;
        end
        if (issueValid) begin
            busyNext[issueAddr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busyNext[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busyVec <= '0;
        end else begin
            busyVec <= busyNext;
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// Register bank with two combinational read ports, one write port and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and clear busy) onto matching read ports.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = addrWidth(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                regWrite,
    input  logic [ADDR_W-1:0]   wrAddr,
    input  logic [DATA_W-1:0]   writeData,
    input  logic [ADDR_W-1:0]   rdAddr1,
    input  logic [ADDR_W-1:0]   rdAddr2,
    output logic [DATA_W-1:0]   rdData1,
    output logic [DATA_W-1:0]   rdData2,
    input  logic                issueValid,
    input  logic [ADDR_W-1:0]   issueAddr,
    output logic                rdBusy1,
    output logic                rdBusy2,
    output logic [NUM_REGS-1:0] busyVec
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] writeEn;
    logic                zeroRd1;
    logic                zeroRd2;

    always_comb begin
        writeEn = '0;
        if (regWrite) begin
            writeEn[wrAddr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            writeEn[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (writeEn[i]) begin
                    regs[i] <= writeData;
                end
            end
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .regWrite   (regWrite),
        .wrAddr     (wrAddr),
        .issueValid (issueValid),
        .issueAddr  (issueAddr),
        .busyVec    (busyVec)
    );

    assign zeroRd1 = (ZERO_REG != 0) && (rdAddr1 == '0);
    assign zeroRd2 = (ZERO_REG != 0) && (rdAddr2 == '0);

    always_comb begin
        rdData1 = zeroRd1 ? '0 : regs[rdAddr1];
        rdData2 = zeroRd2 ? '0 : regs[rdAddr2];
        rdBusy1 = busyVec[rdAddr1];
        rdBusy2 = busyVec[rdAddr2];
`ifdef REGFILE_BYPASS_EN
        // A retiring write satisfies the reader now, unless a new producer claims the same register.
        if (regWrite && (wrAddr == rdAddr1) && !zeroRd1) begin
            rdData1 = writeData;
            if (!(issueValid && (issueAddr == rdAddr1))) begin
                rdBusy1 = 1'b0;
            end
        end
        if (regWrite && (wrAddr == rdAddr2) && !zeroRd2) begin
            rdData2 = writeData;
            if (!(issueValid && (issueAddr == rdAddr2))) begin
                rdBusy2 = 1'b0;
            end
        end
`endif
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: a reference model predicts read results, which are
// queued when addresses are driven and compared when the DUT outputs are sampled.
module tb_regfile_multiport;
    import regfile_pkg::*;

    localparam int DW = 16;
    localparam int NR = 8;
    localparam int AW = 3;

    typedef struct {
        string       tag;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic        b1;
        logic        b2;
        logic [NR-1:0] bv;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          regWrite = 1'b0;
    logic [AW-1:0] wrAddr = '0;
    logic [DW-1:0] writeData = '0;
    logic [AW-1:0] rdAddr1 = '0;
    logic [AW-1:0] rdAddr2 = '0;
    logic [DW-1:0] rdData1;
    logic [DW-1:0] rdData2;
    logic          issueValid = 1'b0;
    logic [AW-1:0] issueAddr = '0;
    logic          rdBusy1;
    logic          rdBusy2;
    logic [NR-1:0] busyVec;

    int nCompared = 0;
    int nMismatched = 0;

    logic [DW-1:0] mReg [NR];
    logic [NR-1:0] mBusy;
    exp_t          expQ [$];

    regfile_multiport #(.DATA_W(DW), .NUM_REGS(NR), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset), .regWrite(regWrite), .wrAddr(wrAddr),
        .writeData(writeData), .rdAddr1(rdAddr1), .rdAddr2(rdAddr2),
        .rdData1(rdData1), .rdData2(rdData2), .issueValid(issueValid),
        .issueAddr(issueAddr), .rdBusy1(rdBusy1), .rdBusy2(rdBusy2),
        .busyVec(busyVec)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mRead(input logic [AW-1:0] a);
        return (a == 0) ? '0 : mReg[a];
    endfunction

    // One clock edge with the given controls; the model applies write/clear, then set (set wins).
    task automatic doEdge(input logic rst, input logic wr, input logic [AW-1:0] wa,
                          input logic [DW-1:0] wd, input logic iv, input logic [AW-1:0] ia);
        reset = rst; regWrite = wr; wrAddr = wa; writeData = wd;
        issueValid = iv; issueAddr = ia;
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < NR; i++) mReg[i] = '0;
            mBusy = '0;
        end else begin
            if (wr && wa != 0) mReg[wa] = wd;
            if (wr) mBusy[wa] = 1'b0;
            if (iv) mBusy[ia] = 1'b1;
            mBusy[0] = 1'b0;
        end
        #1;
        reset = 1'b1; regWrite = 1'b0; issueValid = 1'b0;
    endtask

    task automatic popCompare();
        exp_t e;
        if (expQ.size() == 0) begin
            checkVal("queue_empty", 64'd1, 64'd0);
            return;
        end
        e = expQ.pop_front();
        checkVal({e.tag, ".rdData1"}, 64'(rdData1), 64'(e.d1));
        checkVal({e.tag, ".rdData2"}, 64'(rdData2), 64'(e.d2));
        checkVal({e.tag, ".rdBusy1"}, 64'(rdBusy1), 64'(e.b1));
        checkVal({e.tag, ".rdBusy2"}, 64'(rdBusy2), 64'(e.b2));
        checkVal({e.tag, ".busyVec"}, 64'(busyVec), 64'(e.bv));
    endtask

    // Quiet-cycle read: drive addresses, queue the model prediction, sample after settling.
    task automatic readCheck(input string tag, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        exp_t e;
        @(negedge clk);
        rdAddr1 = a1; rdAddr2 = a2;
        e.tag = tag; e.d1 = mRead(a1); e.d2 = mRead(a2);
        e.b1 = mBusy[a1]; e.b2 = mBusy[a2]; e.bv = mBusy;
        expQ.push_back(e);
        #1;
        popCompare();
    endtask

    initial begin
        for (int i = 0; i < NR; i++) mReg[i] = 'x;
        mBusy = 'x;

        doEdge(1'b0, 1'b1, 3'd3, 16'hAAAA, 1'b1, 3'd3);
        doEdge(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
        for (int i = 0; i < NR; i++) readCheck("reset_read", AW'(i), AW'((i + 1) % NR));

        doEdge(1'b1, 1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0);
        readCheck("write_r3", 3'd3, 3'd3);
        doEdge(1'b1, 1'b1, 3'd0, 16'h1234, 1'b0, 3'd0);
        readCheck("write_r0", 3'd0, 3'd3);

        doEdge(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5);
        readCheck("issue_r5", 3'd3, 3'd5);
        doEdge(1'b1, 1'b1, 3'd5, 16'h00AA, 1'b0, 3'd0);
        readCheck("retire_r5", 3'd5, 3'd5);
        doEdge(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd0);
        readCheck("issue_r0", 3'd0, 3'd5);

        doEdge(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2);
        readCheck("issue_r2", 3'd2, 3'd2);
        doEdge(1'b1, 1'b1, 3'd2, 16'h5555, 1'b1, 3'd2);
        readCheck("set_wins_r2", 3'd2, 3'd2);
        doEdge(1'b1, 1'b1, 3'd2, 16'h6666, 1'b1, 3'd4);
        readCheck("split_r2_r4", 3'd2, 3'd4);

        doEdge(1'b1, 1'b1, 3'd1, 16'h0F0F, 1'b1, 3'd6);
        doEdge(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd1);
        readCheck("pre_reset", 3'd1, 3'd6);
        doEdge(1'b0, 1'b1, 3'd1, 16'hFFFF, 1'b1, 3'd7);
        readCheck("mid_reset", 3'd1, 3'd6);
        readCheck("mid_reset_r7", 3'd7, 3'd4);

        doEdge(1'b1, 1'b1, 3'd7, 16'h1111, 1'b1, 3'd7);
        readCheck("prep_r7", 3'd7, 3'd0);
        begin
            exp_t e;
            @(negedge clk);
            regWrite = 1'b1; wrAddr = 3'd7; writeData = 16'hCAFE;
            issueValid = 1'b0; rdAddr1 = 3'd7; rdAddr2 = 3'd0;
            e.tag = "bypass_r7";
`ifdef REGFILE_BYPASS_EN
            e.d1 = 16'hCAFE; e.b1 = 1'b0;
`else
            e.d1 = mReg[7];  e.b1 = mBusy[7];
`endif
            e.d2 = '0; e.b2 = 1'b0; e.bv = mBusy;
            expQ.push_back(e);
            #1;
            popCompare();
            doEdge(1'b1, 1'b1, 3'd7, 16'hCAFE, 1'b0, 3'd0);
        end
        readCheck("after_bypass", 3'd7, 3'd7);

        for (int n = 0; n < 40; n++) begin
            doEdge(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)),
                   DW'($urandom), 1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)));
            readCheck("random", AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)));
        end

        if (expQ.size() != 0) checkVal("queue_leftover", 64'(expQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the single 16-bit enable-gated register: a bank of NUM_REGS registers, each DATA_W bits wide, with an internal write decoder.
- Provides two asynchronous read ports and one synchronous write port.
- Keeps a per-register busy scoreboard so the datapath can stall on registers with pending writes.
- Sits between decode and execute in the CPU datapath and replaces the hand-instantiated register array plus external decoder.

Parameters:
- DATA_W, 16, bits per register (1..64).
- NUM_REGS, 8, number of registers; power of two, 2..32.
- ADDR_W, $clog2(NUM_REGS), address width; derived, not overridden.
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes and busy-set.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- regWrite  in  1  write enable
- wrAddr  in  ADDR_W  write destination
- writeData  in  DATA_W  write data
- rdAddr1  in  ADDR_W  read port 1 address
- rdAddr2  in  ADDR_W  read port 2 address
- rdData1  out  DATA_W  read port 1 data
- rdData2  out  DATA_W  read port 2 data
- issueValid  in  1  instruction issued; marks issueAddr busy
- issueAddr  in  ADDR_W  destination register of the issued instruction
- rdBusy1  out  1  register at rdAddr1 has a pending write
- rdBusy2  out  1  register at rdAddr2 has a pending write
- busyVec  out  NUM_REGS  full scoreboard, bit i means register i is busy

Behaviour:
- Reset: on a rising clk with reset==0, all registers clear to 0 and all busy bits clear to 0, overriding any same-cycle regWrite or issueValid. Output values during reset follow from that cleared state (reads return 0, busy outputs 0).
- Write: on a rising clk with reset==1 and regWrite==1, reg[wrAddr] takes writeData. Exception: no write when ZERO_REG==1 and wrAddr==0.
- Read: combinational. rdDataN = reg[rdAddrN], or 0 when ZERO_REG==1 and rdAddrN==0. Without the bypass feature, a write is visible the cycle after its edge.
- Busy clear: on the edge, regWrite==1 clears busy[wrAddr].
- Busy set: on the edge, issueValid==1 sets busy[issueAddr].
- Same register set and cleared on one edge: set wins. The new producer supersedes the retiring one, so the bit stays 1.
- Different addresses on one edge: both the set and the clear apply.
- Zero register: with ZERO_REG==1, busy[0] is constant 0.
- Busy outputs: rdBusyN = busy[rdAddrN], combinational. busyVec mirrors busy directly.
- Writing a non-busy register is legal; the data is written and busy stays 0.
- Both read ports may address the same register; both return the same value.
- Latency: write-to-read 1 cycle (0 with bypass); issue-to-busy visible 1 cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when regWrite==1 and wrAddr==rdAddrN (excluding register 0 under ZERO_REG), rdDataN = writeData in the same cycle. rdBusyN is also forced to 0 for that port in that cycle unless issueValid targets the same address.
- Undefined: no forwarding; reads return stored contents and busy reflects stored state only.

Decomposition:
- Shared package regfile_pkg:
  - default DATA_W and NUM_REGS constants
  - ADDR_W derivation function
  - a reg_addr_t typedef
- One natural sub-module, regfile_scoreboard: the NUM_REGS busy bits with set/clear priority logic; outputs busyVec.
- Storage, decoder and read muxes stay in the top module.

Test Plan:
- Reset and reads: hold reset=0 for 2 cycles, then release; read all addresses -> every rdData=0 and busyVec=0.
- Write then read: write 0xBEEF to r3; next cycle rdAddr1=3 -> rdData1=0xBEEF. Write 0x1234 to r0 -> r0 still reads 0.
- Scoreboard set/clear: issueValid with issueAddr=5 -> busyVec[5]=1 next cycle and rdBusy2=1 at rdAddr2=5. Then regWrite to r5 with 0x00AA -> busy[5]=0 next cycle, reads 0x00AA.
- Simultaneous set and clear: r2 busy; same edge regWrite to r2 and issueValid to r2 -> busy[2] stays 1 and data updates. Repeat with issueAddr=4 -> busy[2]=0 and busy[4]=1.
- Reset mid-operation: with busy r1 and r6 set and r1=0x0F0F, assert reset=0 for one edge together with regWrite to r1 -> r1=0 and busyVec=0.
- Bypass (REGFILE_BYPASS_EN): regWrite to r7 with 0xCAFE and rdAddr1=7 in the same cycle -> rdData1=0xCAFE combinationally. Without the macro, rdData1 shows the old r7 value.
